warp_ahb_sram: RTL and testbench
================================

Name: warp_ahb_sram

Overview:
- AHB5 subordinate that answers manager requests (icache line fills, future LSU traffic) from an on-chip dword-wide SRAM.
- Implements the standard address-phase/data-phase pipeline with a configurable number of wait states, byte-strobed writes, and the two-cycle ERROR response.
- Sits on the memory side of the fetch bus as the backing store for simulation and FPGA bring-up.

Parameters:
- DEPTH_LOG2, 12, log2 of number of 64-bit words (default 4096 words = 32 KiB).
- BASE_ADDR, 64'h0, byte address of word 0; must be aligned to 8<<DEPTH_LOG2.
- WAIT_STATES, 0, number of hready-low cycles inserted in every OKAY data phase (0..15).

Ports:
- i_clk  in  1  clock; also the AHB HCLK.
- i_rst_n  in  1  asynchronous active-low reset (HRESETn).
- i_ahb_haddr  in  64  byte address.
- i_ahb_hburst  in  3  accepted, ignored; each beat is decoded independently.
- i_ahb_hmastlock  in  1  ignored.
- i_ahb_hprot  in  4  ignored.
- i_ahb_hsize  in  3  transfer size; 0..3 legal.
- i_ahb_hnonsec  in  1  ignored.
- i_ahb_hexcl  in  1  exclusive-access flag; used only with the optional feature.
- i_ahb_htrans  in  2  IDLE/BUSY/NONSEQ/SEQ.
- i_ahb_hwdata  in  64  write data, sampled in the data phase.
- i_ahb_hwstrb  in  8  byte write strobes, sampled in the data phase.
- i_ahb_hwrite  in  1  1 = write.
- i_ahb_hsel  in  1  subordinate select.
- o_ahb_hrdata  out  64  read data.
- o_ahb_hready  out  1  transfer done / subordinate ready.
- o_ahb_hresp  out  1  0 = OKAY, 1 = ERROR.
- o_ahb_hexokay  out  1  exclusive OKAY.

Behaviour:
- Reset values: o_ahb_hready=1, o_ahb_hresp=0, o_ahb_hrdata=0, o_ahb_hexokay=0; FSM=DP_NONE. Memory contents are not reset.
- Address phase is accepted at a rising edge when o_ahb_hready=1, i_ahb_hsel=1 and htrans is NONSEQ or SEQ.
- On acceptance, latch word index, haddr[2:0], hsize, hwrite and hexcl.
- IDLE, BUSY or unselected transfers get a zero-wait OKAY (hready=1, hresp=0).
- An accepted transfer is an error if any of these holds:
  - address is outside [BASE_ADDR, BASE_ADDR + 8<<DEPTH_LOG2);
  - hsize > 3;
  - haddr is misaligned to the transfer size.
- FSM states:
  - DP_NONE → DP_WAIT when the transfer is OK and WAIT_STATES > 0.
  - DP_NONE → DP_DONE when the transfer is OK and WAIT_STATES = 0 (the data phase completes in the next cycle).
  - DP_NONE → DP_ERR1 when the transfer is an error.
  - DP_WAIT: hready=0, hresp=0; the counter counts down from WAIT_STATES; → DP_DONE when the count reaches 1.
  - DP_DONE: hready=1, hresp=0; a new address phase may be accepted in the same cycle (pipelined).
  - DP_ERR1: hready=0, hresp=1 → DP_ERR2.
  - DP_ERR2: hready=1, hresp=1. Any address phase offered during DP_ERR2 is accepted normally. Erroring transfers never touch memory.
- Read data:
  - o_ahb_hrdata holds the full addressed dword, with no lane shifting, during the DP_DONE cycle.
  - Read latency is 1 cycle after the address phase plus WAIT_STATES.
  - hrdata holds its last value outside read data phases.
- Write commit:
  - Occurs on the edge that ends DP_DONE.
  - Enables byte i when i_ahb_hwstrb[i] is set AND byte i lies in the size/offset lane mask from haddr[2:0] and hsize.
  - A write with hwstrb=0 completes OKAY and changes nothing.
- Forwarding: a read whose address phase coincides with a committing write to the same word returns the merged (post-write) bytes.
- Reset mid-transfer: the FSM returns to DP_NONE and hready=1, and a pending write does not commit.

Optional Feature:
- Macro: WARP_AHB_EXCL_EN.
- Defined:
  - Single exclusive monitor (valid bit + word address).
  - A successful exclusive read sets the monitor and completes with hexokay=1.
  - An exclusive write to the monitored word commits, completes with hexokay=1, and clears the monitor.
  - Otherwise an exclusive write is suppressed (no commit), OKAY, hexokay=0.
  - Any non-exclusive committed write to the monitored word clears the monitor.
  - Reset clears the monitor.
- Undefined: hexcl is ignored, exclusive writes commit normally, and hexokay is always 0.

Decomposition:
- Shared package warp_ahb_pkg holds:
  - HTRANS_*, HBURST_*, HRESP_OKAY=0 and HRESP_ERROR=1 constants;
  - HSIZE_BYTE/HALF/WORD/DWORD constants;
  - a lane-mask function mapping (haddr[2:0], hsize) to an 8-bit mask.
- The icache manager imports the same package.
- Sub-module warp_ahb_sram_array: 2^DEPTH_LOG2 x 64 synchronous array with an 8-bit byte write enable, one write port and one read port.

Test Plan:
- Preload word i = 64'hA5A5_0000_0000_0000 + i. NONSEQ+7xSEQ WRAP8 read from 0x40, WAIT_STATES=0 → eight hready-high data phases returning words 8..15 in address order, hresp=0 throughout.
- Write 0x0000_0000_DEAD_BEEF to 0x100 (hsize=2, hwstrb=8'h0F), then read 0x100 back-to-back → the read returns upper bytes unchanged and lower bytes 0xDEADBEEF via the forwarding path.
- WAIT_STATES=3, single read of 0x08 → hready low for exactly 3 cycles, then high with word 1.
- Read from BASE_ADDR + 0x8000 (out of range) → one cycle hready=0/hresp=1, then one cycle hready=1/hresp=1; a following valid read completes OKAY.
- Halfword write to 0x3 (misaligned) → two-cycle ERROR; memory word 0 is unchanged.
- Assert i_rst_n low during a DP_WAIT write → hready=1 and hresp=0 immediately; the target word is unchanged after reset.

Source files
------------

// File: rtl/warp_ahb_pkg.sv
// -----------------------------------------------------------------------------
// warp_ahb_pkg
// Shared AHB5 definitions for the warp fetch bus: transfer-type, burst,
// response and size encodings, the subordinate data-phase state type, and a
// helper that turns (haddr[2:0], hsize) into the active byte lanes of a
// 64-bit data bus. Imported by warp_ahb_sram and the icache manager.
// -----------------------------------------------------------------------------
package warp_ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [2:0] HBURST_INCR   = 3'b001;
  localparam logic [2:0] HBURST_WRAP4  = 3'b010;
  localparam logic [2:0] HBURST_INCR4  = 3'b011;
  localparam logic [2:0] HBURST_WRAP8  = 3'b100;
  localparam logic [2:0] HBURST_INCR8  = 3'b101;
  localparam logic [2:0] HBURST_WRAP16 = 3'b110;
  localparam logic [2:0] HBURST_INCR16 = 3'b111;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  localparam logic [2:0] HSIZE_BYTE  = 3'd0;
  localparam logic [2:0] HSIZE_HALF  = 3'd1;
  localparam logic [2:0] HSIZE_WORD  = 3'd2;
  localparam logic [2:0] HSIZE_DWORD = 3'd3;

  // Subordinate data-phase tracking.
  typedef enum logic [2:0] {
    DP_NONE,  // no data phase in flight, bus ready
    DP_WAIT,  // OKAY transfer stalled by wait states
    DP_DONE,  // OKAY data phase completing this cycle
    DP_ERR1,  // first ERROR cycle (hready low)
    DP_ERR2   // second ERROR cycle (hready high)
  } dp_state_e;

  // Byte lanes touched by a transfer of the given size at the given offset.
  // Callers only pass aligned, legal sizes; anything else yields no lanes.
  function automatic logic [7:0] lane_mask(input logic [2:0] offset,
                                           input logic [2:0] size);
    logic [7:0] base;
    case (size)
      HSIZE_BYTE:  base = 8'h01;
      HSIZE_HALF:  base = 8'h03;
      HSIZE_WORD:  base = 8'h0F;
      HSIZE_DWORD: base = 8'hFF;
      default:     base = 8'h00;
    endcase
    return base << offset;
  endfunction

endpackage

// File: rtl/warp_ahb_sram_array.sv
// -----------------------------------------------------------------------------
// warp_ahb_sram_array
// 2^DEPTH_LOG2 x 64-bit synchronous SRAM, one byte-enabled write port and one
// registered read port. Read-during-write to the same word returns the old
// contents; the AHB wrapper forwards around that case.
//
// Ports:
//   i_clk    clock
//   i_we     8-bit byte write enable
//   i_waddr  write word index
//   i_wdata  write data
//   i_re     read enable; o_rdata holds its value when low
//   i_raddr  read word index
//   o_rdata  registered read data
// -----------------------------------------------------------------------------
module warp_ahb_sram_array #(
  parameter int DEPTH_LOG2 = 12
) (
  input  logic                  i_clk,
  input  logic [7:0]            i_we,
  input  logic [DEPTH_LOG2-1:0] i_waddr,
  input  logic [63:0]           i_wdata,
  input  logic                  i_re,
  input  logic [DEPTH_LOG2-1:0] i_raddr,
  output logic [63:0]           o_rdata
);

  logic [63:0] mem [0:(1<<DEPTH_LOG2)-1];

  // NOTE: no reset here -- a resettable array cannot map onto block RAM, and
  // the storage contents are deliberately left untouched across reset.
  always_ff @(posedge i_clk) begin
    // NOTE: non-blocking assignments keep every flop sampling pre-edge values,
    // so the read below sees the old word even when the write hits it.
    for (int b = 0; b < 8; b++) begin
      if (i_we[b]) mem[i_waddr][b*8 +: 8] <= i_wdata[b*8 +: 8];
    end
    if (i_re) o_rdata <= mem[i_raddr];
  end

endmodule

// File: rtl/warp_ahb_sram.sv
// -----------------------------------------------------------------------------
// warp_ahb_sram
// AHB5 subordinate backed by a dword-wide on-chip SRAM. Pipelined address /
// data phases, WAIT_STATES stall cycles per OKAY data phase, byte-strobed
// writes committed at the end of the data phase, and the two-cycle ERROR
// response for out-of-range, oversize or misaligned transfers.
//
// Build option: define WARP_AHB_EXCL_EN to add a single exclusive-access
// monitor (hexcl / hexokay). Without it hexcl is ignored and hexokay is 0.
//
// Parameters:
//   DEPTH_LOG2   log2 of the number of 64-bit words
//   BASE_ADDR    byte address of word 0, aligned to 8<<DEPTH_LOG2
//   WAIT_STATES  hready-low cycles per OKAY data phase (0..15)
//
// Ports:
//   i_clk, i_rst_n                 HCLK, asynchronous active-low HRESETn
//   i_ahb_haddr/hsize/htrans/...   address-phase inputs
//   i_ahb_hburst/hmastlock/hprot/hnonsec  accepted and ignored
//   i_ahb_hexcl                    exclusive flag (optional feature only)
//   i_ahb_hwdata, i_ahb_hwstrb     data-phase write data and byte strobes
//   o_ahb_hrdata                   read data, held between read data phases
//   o_ahb_hready, o_ahb_hresp      transfer done, OKAY/ERROR response
//   o_ahb_hexokay                  exclusive OKAY
// -----------------------------------------------------------------------------
module warp_ahb_sram
  import warp_ahb_pkg::*;
#(
  parameter int          DEPTH_LOG2  = 12,
  parameter logic [63:0] BASE_ADDR   = 64'h0,
  parameter int          WAIT_STATES = 0
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [63:0] i_ahb_haddr,
  input  logic [2:0]  i_ahb_hburst,
  input  logic        i_ahb_hmastlock,
  input  logic [3:0]  i_ahb_hprot,
  input  logic [2:0]  i_ahb_hsize,
  input  logic        i_ahb_hnonsec,
  input  logic        i_ahb_hexcl,
  input  logic [1:0]  i_ahb_htrans,
  input  logic [63:0] i_ahb_hwdata,
  input  logic [7:0]  i_ahb_hwstrb,
  input  logic        i_ahb_hwrite,
  input  logic        i_ahb_hsel,
  output logic [63:0] o_ahb_hrdata,
  output logic        o_ahb_hready,
  output logic        o_ahb_hresp,
  output logic        o_ahb_hexokay
);

  localparam int         AW = DEPTH_LOG2 + 3;  // byte-address bits inside the array
  localparam logic [3:0] WS = 4'(WAIT_STATES);

  dp_state_e             state_q, state_d;
  logic [3:0]            cnt_q;
  logic [DEPTH_LOG2-1:0] idx_q;
  logic [2:0]            off_q, size_q;
  logic                  write_q;

  logic                  accept, xfer_err, misalign, out_of_range;
  logic [DEPTH_LOG2-1:0] addr_idx;
  logic                  commit_ok;
  logic [7:0]            wr_be;
  logic                  rd_en;
  logic [DEPTH_LOG2-1:0] rd_idx;
  logic [63:0]           arr_rdata;
  logic [7:0]            fwd_be_q;
  logic [63:0]           fwd_data_q;
  logic                  unused_inputs;

  assign unused_inputs = ^{i_ahb_hburst, i_ahb_hmastlock, i_ahb_hprot,
                           i_ahb_hnonsec, i_ahb_htrans[0], i_ahb_hexcl};

  // The bus is ready in every state except the stalled ones, so acceptance
  // is decoded from the state directly rather than from o_ahb_hready.
  assign accept   = i_ahb_hsel && i_ahb_htrans[1] &&
                    (state_q != DP_WAIT) && (state_q != DP_ERR1);
  assign addr_idx = i_ahb_haddr[AW-1:3];

  // ---------------------------------------------------------------------------
  // Address-phase legality
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal assigned in always_comb gets a default first so that
    // no path leaves it unassigned and a latch is inferred.
    misalign = 1'b0;
    case (i_ahb_hsize)
      HSIZE_HALF:  misalign = i_ahb_haddr[0];
      HSIZE_WORD:  misalign = |i_ahb_haddr[1:0];
      HSIZE_DWORD: misalign = |i_ahb_haddr[2:0];
      default:     misalign = 1'b0;  // bytes never misalign; >3 caught below
    endcase
  end

  // BASE_ADDR is aligned to the array span, so range is a high-bits compare.
  assign out_of_range = i_ahb_haddr[63:AW] != BASE_ADDR[63:AW];
  assign xfer_err     = out_of_range || i_ahb_hsize[2] || misalign;

  // ---------------------------------------------------------------------------
  // Data-phase FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= DP_NONE;
      cnt_q   <= 4'd0;
      idx_q   <= '0;
      off_q   <= 3'd0;
      size_q  <= 3'd0;
      write_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        idx_q   <= addr_idx;
        off_q   <= i_ahb_haddr[2:0];
        size_q  <= i_ahb_hsize;
        write_q <= i_ahb_hwrite;
        cnt_q   <= WS;
      end else if (state_q == DP_WAIT) begin
        cnt_q <= cnt_q - 4'd1;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    o_ahb_hready = 1'b1;
    o_ahb_hresp  = HRESP_OKAY;
    case (state_q)
      DP_WAIT: begin
        o_ahb_hready = 1'b0;
        if (cnt_q == 4'd1) state_d = DP_DONE;
      end
      DP_ERR1: begin
        o_ahb_hready = 1'b0;
        o_ahb_hresp  = HRESP_ERROR;
        state_d      = DP_ERR2;
      end
      default: begin
        // DP_NONE, DP_DONE and DP_ERR2 all present hready=1 and may take a
        // new address phase in the same cycle.
        if (state_q == DP_ERR2) o_ahb_hresp = HRESP_ERROR;
        if (!accept)            state_d = DP_NONE;
        else if (xfer_err)      state_d = DP_ERR1;
        else if (WS == 4'd0)    state_d = DP_DONE;
        else                    state_d = DP_WAIT;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Exclusive monitor
  // ---------------------------------------------------------------------------
`ifdef WARP_AHB_EXCL_EN
  logic                  excl_q;
  logic                  mon_valid_q;
  logic [DEPTH_LOG2-1:0] mon_idx_q;
  logic                  mon_hit;

  assign mon_hit       = mon_valid_q && (mon_idx_q == idx_q);
  // An exclusive write only lands if the monitor still covers its word.
  assign commit_ok     = !(excl_q && write_q) || mon_hit;
  assign o_ahb_hexokay = (state_q == DP_DONE) && excl_q && (!write_q || mon_hit);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      excl_q      <= 1'b0;
      mon_valid_q <= 1'b0;
      mon_idx_q   <= '0;
    end else begin
      if (accept) excl_q <= i_ahb_hexcl;
      if (state_q == DP_DONE) begin
        if (excl_q && !write_q) begin
          mon_valid_q <= 1'b1;
          mon_idx_q   <= idx_q;
        end else if (write_q && mon_hit) begin
          // Successful exclusive write or any plain write to the word.
          mon_valid_q <= 1'b0;
        end
      end
    end
  end
`else
  assign commit_ok     = 1'b1;
  assign o_ahb_hexokay = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Storage, read capture and forwarding
  // ---------------------------------------------------------------------------
  assign wr_be = (state_q == DP_DONE && write_q && commit_ok)
               ? (i_ahb_hwstrb & lane_mask(off_q, size_q)) : 8'h00;

  // Read data is captured on the edge that enters DP_DONE: straight from the
  // address phase with no wait states, otherwise from the latched index.
  always_comb begin
    rd_en  = 1'b0;
    rd_idx = idx_q;
    if (state_q == DP_WAIT) begin
      rd_en = (cnt_q == 4'd1) && !write_q;
    end else if (accept && !xfer_err && WS == 4'd0) begin
      rd_en  = !i_ahb_hwrite;
      rd_idx = addr_idx;
    end
  end

  warp_ahb_sram_array #(
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_array (
    .i_clk   (i_clk),
    .i_we    (wr_be),
    .i_waddr (idx_q),
    .i_wdata (i_ahb_hwdata),
    .i_re    (rd_en),
    .i_raddr (rd_idx),
    .o_rdata (arr_rdata)
  );

  // Bytes committed on the same edge as the read are overlaid on the array's
  // stale output. Resetting the overlay to all-lanes/zero also gives the
  // required hrdata=0 after reset without resetting the array output.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      fwd_be_q   <= 8'hFF;
      fwd_data_q <= 64'h0;
    end else if (rd_en) begin
      fwd_be_q   <= (rd_idx == idx_q) ? wr_be : 8'h00;
      fwd_data_q <= i_ahb_hwdata;
    end
  end

  always_comb begin
    o_ahb_hrdata = 64'h0;
    for (int b = 0; b < 8; b++) begin
      o_ahb_hrdata[b*8 +: 8] = fwd_be_q[b] ? fwd_data_q[b*8 +: 8] : arr_rdata[b*8 +: 8];
    end
  end

endmodule

// File: tb/tb_warp_ahb_sram.sv
// -----------------------------------------------------------------------------
// tb_warp_ahb_sram
// Two instances (WAIT_STATES 0 and 3) driven by a pipelined AHB master. A
// transfer-level reference (flat memory image, legality rules, exclusive
// monitor) predicts the response, stall length and read data of every beat.
// -----------------------------------------------------------------------------
module tb_warp_ahb_sram;
  import warp_ahb_pkg::*;

  localparam int          NWORDS = 4096;
  localparam logic [63:0] SPAN   = 64'd8 * NWORDS;

  typedef struct {
    logic [1:0]  trans;
    logic        sel;
    logic [63:0] addr;
    logic [2:0]  size;
    logic        write;
    logic [63:0] wdata;
    logic [7:0]  strb;
    logic        excl;
    logic [2:0]  burst;
  } xfer_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n     [2];
  logic [63:0] haddr     [2];
  logic [2:0]  hburst    [2];
  logic        hmastlock [2];
  logic [3:0]  hprot     [2];
  logic [2:0]  hsize     [2];
  logic        hnonsec   [2];
  logic        hexcl     [2];
  logic [1:0]  htrans    [2];
  logic [63:0] hwdata    [2];
  logic [7:0]  hwstrb    [2];
  logic        hwrite    [2];
  logic        hsel      [2];
  logic [63:0] hrdata    [2];
  logic        hready    [2];
  logic        hresp     [2];
  logic        hexokay   [2];

  warp_ahb_sram #(.WAIT_STATES(0)) dut0 (
    .i_clk(clk), .i_rst_n(rst_n[0]), .i_ahb_haddr(haddr[0]), .i_ahb_hburst(hburst[0]),
    .i_ahb_hmastlock(hmastlock[0]), .i_ahb_hprot(hprot[0]), .i_ahb_hsize(hsize[0]),
    .i_ahb_hnonsec(hnonsec[0]), .i_ahb_hexcl(hexcl[0]), .i_ahb_htrans(htrans[0]),
    .i_ahb_hwdata(hwdata[0]), .i_ahb_hwstrb(hwstrb[0]), .i_ahb_hwrite(hwrite[0]),
    .i_ahb_hsel(hsel[0]), .o_ahb_hrdata(hrdata[0]), .o_ahb_hready(hready[0]),
    .o_ahb_hresp(hresp[0]), .o_ahb_hexokay(hexokay[0]));

  warp_ahb_sram #(.WAIT_STATES(3)) dut3 (
    .i_clk(clk), .i_rst_n(rst_n[1]), .i_ahb_haddr(haddr[1]), .i_ahb_hburst(hburst[1]),
    .i_ahb_hmastlock(hmastlock[1]), .i_ahb_hprot(hprot[1]), .i_ahb_hsize(hsize[1]),
    .i_ahb_hnonsec(hnonsec[1]), .i_ahb_hexcl(hexcl[1]), .i_ahb_htrans(htrans[1]),
    .i_ahb_hwdata(hwdata[1]), .i_ahb_hwstrb(hwstrb[1]), .i_ahb_hwrite(hwrite[1]),
    .i_ahb_hsel(hsel[1]), .o_ahb_hrdata(hrdata[1]), .o_ahb_hready(hready[1]),
    .o_ahb_hresp(hresp[1]), .o_ahb_hexokay(hexokay[1]));

  // Reference state per instance.
  logic [63:0] mdl     [2][NWORDS];
  logic [63:0] last_rd [2];
  bit          mon_v   [2];
  int          mon_i   [2];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic int wait_of(input int d);
    return (d == 0) ? 0 : 3;
  endfunction

  function automatic bit is_err(input logic [63:0] a, input logic [2:0] sz);
    if (a >= SPAN) return 1'b1;
    if (sz > 3'd3) return 1'b1;
    if ((a % (64'd1 << sz)) != 64'd0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic xfer_t mk(input logic [1:0] trans, input logic [63:0] addr,
                               input logic [2:0] size, input logic write,
                               input logic [63:0] wdata, input logic [7:0] strb,
                               input logic excl);
    xfer_t x;
    x.trans = trans; x.sel = 1'b1; x.addr = addr; x.size = size; x.write = write;
    x.wdata = wdata; x.strb = strb; x.excl = excl; x.burst = HBURST_INCR;
    return x;
  endfunction

  task automatic drive_idle(input int d);
    htrans[d] = HTRANS_IDLE; hsel[d] = 1'b0; haddr[d] = 64'h0; hsize[d] = 3'd0;
    hwrite[d] = 1'b0; hexcl[d] = 1'b0; hburst[d] = HBURST_SINGLE;
    hmastlock[d] = 1'b0; hprot[d] = 4'h3; hnonsec[d] = 1'b0;
    hwdata[d] = 64'h0; hwstrb[d] = 8'h00;
  endtask

  // Retire one OKAY beat against the reference: returns expected hexokay.
  function automatic bit retire(input int d, input xfer_t x);
    int  w = int'(x.addr[14:3]);
    int  off = int'(x.addr[2:0]);
    int  nbytes = 1 << x.size;
    bit  xok = 1'b0;
    bit  commit = 1'b1;
`ifdef WARP_AHB_EXCL_EN
    bit hit = mon_v[d] && (mon_i[d] == w);
    if (x.excl && !x.write) begin xok = 1'b1; mon_v[d] = 1'b1; mon_i[d] = w; end
    if (x.excl && x.write) begin xok = hit; commit = hit; end
    if (x.write && hit) mon_v[d] = 1'b0;
`endif
    if (x.write && commit) begin
      for (int b = 0; b < 8; b++) begin
        if (x.strb[b] && b >= off && b < off + nbytes) mdl[d][w][b*8 +: 8] = x.wdata[b*8 +: 8];
      end
    end
    return xok;
  endfunction

  // Pipelined master: one address phase per ready cycle, data phases checked
  // for response, stall length, read data and hold behaviour.
  task automatic run(input int d, input xfer_t q[$]);
    int    ai = 0;
    bit    dv = 1'b0;
    bit    d_err = 1'b0;
    bit    rdy;
    bit    xok;
    int    low = 0;
    int    cycles = 0;
    xfer_t dx, cur;
    dx = mk(HTRANS_IDLE, 64'h0, 3'd0, 1'b0, 64'h0, 8'h0, 1'b0);
    while ((ai < q.size() || dv) && cycles < 5000) begin
      if (ai < q.size()) begin
        cur = q[ai];
        htrans[d] = cur.trans; hsel[d] = cur.sel; haddr[d] = cur.addr; hsize[d] = cur.size;
        hwrite[d] = cur.write; hexcl[d] = cur.excl; hburst[d] = cur.burst;
      end else begin
        htrans[d] = HTRANS_IDLE; hsel[d] = 1'b0;
      end
      hwdata[d] = dv ? dx.wdata : 64'h0;
      hwstrb[d] = dv ? dx.strb  : 8'h00;
      @(negedge clk);
      rdy = hready[d];
      if (dv) begin
        check($sformatf("d%0d hresp @%h", d, dx.addr), {63'h0, hresp[d]}, {63'h0, d_err});
        if (!rdy) begin
          low++;
        end else begin
          check($sformatf("d%0d stall @%h", d, dx.addr), 64'(low), d_err ? 64'd1 : 64'(wait_of(d)));
          xok = d_err ? 1'b0 : retire(d, dx);
          check($sformatf("d%0d hexokay @%h", d, dx.addr), {63'h0, hexokay[d]}, {63'h0, xok});
        end
      end else begin
        check($sformatf("d%0d idle ready", d), {62'h0, hready[d], hresp[d]}, 64'h2);
      end
      if (dv && rdy && !d_err && !dx.write) begin
        last_rd[d] = mdl[d][int'(dx.addr[14:3])];
        check($sformatf("d%0d hrdata @%h", d, dx.addr), hrdata[d], last_rd[d]);
      end else begin
        check($sformatf("d%0d hrdata hold", d), hrdata[d], last_rd[d]);
      end
      @(posedge clk);
      if (rdy) begin
        dv = 1'b0;
        if (ai < q.size()) begin
          cur = q[ai];
          if (cur.sel && cur.trans[1]) begin
            dv = 1'b1; dx = cur; d_err = is_err(cur.addr, cur.size); low = 0;
          end
          ai++;
        end
      end
      #1;
      cycles++;
    end
    if (cycles >= 5000) check($sformatf("d%0d run cycle budget", d), 64'd1, 64'd0);
    drive_idle(d);
  endtask

  function automatic xfer_t rand_xfer();
    xfer_t x;
    int    kind = $urandom_range(0, 19);
    int    w = $urandom_range(0, 63);
    int    off = $urandom_range(0, 7);
    logic [2:0] sz = 3'($urandom_range(0, 3));
    x = mk(($urandom_range(0, 1) != 0) ? HTRANS_NONSEQ : HTRANS_SEQ, 64'h0, sz,
           1'($urandom_range(0, 1)), {$urandom, $urandom}, 8'($urandom),
           $urandom_range(0, 7) == 0);
    case (kind)
      0: x.trans = HTRANS_IDLE;
      1: x.trans = HTRANS_BUSY;
      2: x.sel = 1'b0;
      3: x.addr = SPAN + 64'($urandom_range(0, 4095)) * 8;
      4: begin x.size = 3'($urandom_range(4, 7)); x.addr = 64'(w * 8 + off); end
      5: begin x.size = 3'($urandom_range(1, 3)); x.addr = 64'(w * 8 + (off | 1)); end
      default: x.addr = 64'(w * 8 + (off - off % (1 << sz)));
    endcase
    return x;
  endfunction

  initial begin
    xfer_t q[$];
    for (int d = 0; d < 2; d++) begin
      drive_idle(d);
      rst_n[d] = 1'b0; last_rd[d] = 64'h0; mon_v[d] = 1'b0; mon_i[d] = 0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("d%0d reset hready", d), {63'h0, hready[d]}, 64'h1);
      check($sformatf("d%0d reset hresp", d), {63'h0, hresp[d]}, 64'h0);
      check($sformatf("d%0d reset hrdata", d), hrdata[d], 64'h0);
      check($sformatf("d%0d reset hexokay", d), {63'h0, hexokay[d]}, 64'h0);
      rst_n[d] = 1'b1;
    end
    @(posedge clk); #1;

    // Preload words 0..63 of both instances through the bus.
    for (int d = 0; d < 2; d++) begin
      q.delete();
      for (int i = 0; i < 64; i++)
        q.push_back(mk((i == 0) ? HTRANS_NONSEQ : HTRANS_SEQ, 64'(i * 8), HSIZE_DWORD, 1'b1,
                       64'hA5A5_0000_0000_0000 + 64'(i), 8'hFF, 1'b0));
      run(d, q);
    end

    // WRAP8 dword read from 0x40: words 8..15 with no stalls.
    q.delete();
    for (int i = 0; i < 8; i++) begin
      q.push_back(mk((i == 0) ? HTRANS_NONSEQ : HTRANS_SEQ, 64'h40 + 64'(i * 8), HSIZE_DWORD,
                     1'b0, 64'h0, 8'h00, 1'b0));
      q[i].burst = HBURST_WRAP8;
    end
    run(0, q);

    // Word write then back-to-back read of the same dword (forwarding path).
    q.delete();
    q.push_back(mk(HTRANS_NONSEQ, 64'h100, HSIZE_WORD, 1'b1, 64'h0000_0000_DEAD_BEEF, 8'h0F, 1'b0));
    q.push_back(mk(HTRANS_NONSEQ, 64'h100, HSIZE_DWORD, 1'b0, 64'h0, 8'h00, 1'b0));
    run(0, q);

    // Wait-state read, then the same write/read pair on the stalled instance.
    q.delete();
    q.push_back(mk(HTRANS_NONSEQ, 64'h08, HSIZE_DWORD, 1'b0, 64'h0, 8'h00, 1'b0));
    q.push_back(mk(HTRANS_NONSEQ, 64'h100, HSIZE_HALF, 1'b1, 64'h0000_0000_0000_1234, 8'hFF, 1'b0));
    q.push_back(mk(HTRANS_NONSEQ, 64'h100, HSIZE_DWORD, 1'b0, 64'h0, 8'h00, 1'b0));
    run(1, q);

    // Errors: out of range read, misaligned halfword write, zero-strobe write,
    // then reads proving recovery and untouched memory; top-of-array boundary.
    q.delete();
    q.push_back(mk(HTRANS_NONSEQ, SPAN, HSIZE_DWORD, 1'b0, 64'h0, 8'h00, 1'b0));
    q.push_back(mk(HTRANS_NONSEQ, 64'h10, HSIZE_DWORD, 1'b0, 64'h0, 8'h00, 1'b0));
    q.push_back(mk(HTRANS_NONSEQ, 64'h3, HSIZE_HALF, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 1'b0));
    q.push_back(mk(HTRANS_NONSEQ, 64'h0, HSIZE_DWORD, 1'b0, 64'h0, 8'h00, 1'b0));
    q.push_back(mk(HTRANS_NONSEQ, 64'h18, HSIZE_DWORD, 1'b1, 64'h1234_5678_9ABC_DEF0, 8'h00, 1'b0));
    q.push_back(mk(HTRANS_NONSEQ, 64'h18, HSIZE_DWORD, 1'b0, 64'h0, 8'h00, 1'b0));
    q.push_back(mk(HTRANS_NONSEQ, SPAN - 8, HSIZE_DWORD, 1'b1, 64'h0123_4567_89AB_CDEF, 8'hFF, 1'b0));
    q.push_back(mk(HTRANS_NONSEQ, SPAN - 8, HSIZE_DWORD, 1'b0, 64'h0, 8'h00, 1'b0));
    q.push_back(mk(HTRANS_NONSEQ, SPAN - 1, HSIZE_BYTE, 1'b0, 64'h0, 8'h00, 1'b0));
    q.push_back(mk(HTRANS_NONSEQ, 64'h28, 3'd4, 1'b0, 64'h0, 8'h00, 1'b0));
    run(0, q);

    // Exclusive sequence: read, write, re-write after the monitor is spent.
    for (int d = 0; d < 2; d++) begin
      q.delete();
      q.push_back(mk(HTRANS_NONSEQ, 64'h20, HSIZE_DWORD, 1'b0, 64'h0, 8'h00, 1'b1));
      q.push_back(mk(HTRANS_NONSEQ, 64'h20, HSIZE_DWORD, 1'b1, 64'h1111_2222_3333_4444, 8'hFF, 1'b1));
      q.push_back(mk(HTRANS_NONSEQ, 64'h20, HSIZE_DWORD, 1'b0, 64'h0, 8'h00, 1'b0));
      q.push_back(mk(HTRANS_NONSEQ, 64'h20, HSIZE_DWORD, 1'b1, 64'h5555_6666_7777_8888, 8'hFF, 1'b1));
      q.push_back(mk(HTRANS_NONSEQ, 64'h20, HSIZE_DWORD, 1'b0, 64'h0, 8'h00, 1'b0));
      run(d, q);
    end

    // Randomised traffic on both instances.
    for (int d = 0; d < 2; d++) begin
      q.delete();
      for (int i = 0; i < 300; i++) q.push_back(rand_xfer());
      run(d, q);
    end

    // Reset during the wait states of a write: bus frees at once, no commit.
    htrans[1] = HTRANS_NONSEQ; hsel[1] = 1'b1; haddr[1] = 64'h30; hsize[1] = HSIZE_DWORD;
    hwrite[1] = 1'b1;
    @(posedge clk); #1;
    drive_idle(1);
    hwdata[1] = 64'hFFFF_0000_FFFF_0000; hwstrb[1] = 8'hFF;
    check("d1 stalled before reset", {63'h0, hready[1]}, 64'h0);
    #2 rst_n[1] = 1'b0;
    #1;
    check("d1 hready in reset", {63'h0, hready[1]}, 64'h1);
    check("d1 hresp in reset", {63'h0, hresp[1]}, 64'h0);
    last_rd[1] = 64'h0; mon_v[1] = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst_n[1] = 1'b1;
    drive_idle(1);
    @(posedge clk); #1;
    q.delete();
    q.push_back(mk(HTRANS_NONSEQ, 64'h30, HSIZE_DWORD, 1'b0, 64'h0, 8'h00, 1'b0));
    run(1, q);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
